// File: rtl/rect_blit_engine_if.sv
// Signal bundle for rect_blit_engine: command handshake, source-memory read port and plot port.
// master = the engine, slave = the surrounding system (controller, source RAM, VGA adapter).
interface rect_blit_engine_if #(
  parameter int unsigned X_W     = 8,
  parameter int unsigned Y_W     = 7,
  parameter int unsigned COLOR_W = 12,
  parameter int unsigned ADDR_W  = 15
) ();

  logic               start;
  logic [1:0]         mode;
  logic [X_W-1:0]     x0;
  logic [X_W-1:0]     x1;
  logic [Y_W-1:0]     y0;
  logic [Y_W-1:0]     y1;
  logic [COLOR_W-1:0] fill_color;

  logic [ADDR_W-1:0]  src_addr;
  logic               src_rd_en;
  logic [COLOR_W-1:0] src_q;

  logic               plot;
  logic [X_W-1:0]     plot_x;
  logic [Y_W-1:0]     plot_y;
  logic [COLOR_W-1:0] plot_color;
  logic               ready;

  logic               busy;
  logic               done;

  modport master (
    input  start, mode, x0, x1, y0, y1, fill_color, src_q, ready,
    output src_addr, src_rd_en, plot, plot_x, plot_y, plot_color, busy, done
  );

  modport slave (
    output start, mode, x0, x1, y0, y1, fill_color, src_q, ready,
    input  src_addr, src_rd_en, plot, plot_x, plot_y, plot_color, busy, done
  );

endinterface

// File: rtl/rect_blit_engine.sv
// Raster-order rectangle walker emitting one plot request per pixel, with fill, mono-expand
// and colour-copy sources; an RD_LAT-deep coordinate pipeline tracks the source RAM latency.
module rect_blit_engine #(
  parameter int unsigned H_RES   = 160,
  parameter int unsigned V_RES   = 120,
  parameter int unsigned X_W     = 8,
  parameter int unsigned Y_W     = 7,
  parameter int unsigned COLOR_W = 12,
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned RD_LAT  = 1
) (
  input logic                clk,
  input logic                resetn,
  rect_blit_engine_if.master bus
);

  localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);
  localparam int unsigned    LAST  = RD_LAT - 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;
  typedef enum logic [1:0] {M_FILL = 2'd0, M_MONO = 2'd1, M_COPY = 2'd2} mode_t;

  state_t             state, state_nx;
  mode_t              mode_q;
  logic [COLOR_W-1:0] fill_q;
  logic [X_W-1:0]     x0_q, x1_q, x_cnt;
  logic [Y_W-1:0]     y1_q, y_cnt;

  logic               pv [RD_LAT];
  logic [X_W-1:0]     px [RD_LAT];
  logic [Y_W-1:0]     py [RD_LAT];

  logic [X_W-1:0]     x1_clamp;
  logic [Y_W-1:0]     y1_clamp;
  logic               empty_rect;
  logic               adv;
  logic               issue;
  logic               last_pix;
  logic               upstream_empty;
  logic               busy_c;
  logic               done_c;
  logic [COLOR_W-1:0] color;

  always_comb begin
    x1_clamp   = (bus.x1 > X_MAX) ? X_MAX : bus.x1;
    y1_clamp   = (bus.y1 > Y_MAX) ? Y_MAX : bus.y1;
    empty_rect = (bus.x0 > X_MAX) || (bus.y0 > Y_MAX) ||
                 (bus.x0 > x1_clamp) || (bus.y0 > y1_clamp);
  end

  assign adv      = !pv[LAST] || bus.ready;
  assign issue    = (state == SCAN) && adv;
  assign last_pix = (x_cnt == x1_q) && (y_cnt == y1_q);

  // Everything but the output stage empty: the next accepted pixel is the final one.
  always_comb begin
    upstream_empty = 1'b1;
    for (int unsigned i = 0; i + 1 < RD_LAT; i++) begin
      if (pv[i]) upstream_empty = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) state_nx = empty_rect ? FIN : SCAN;
      end
      SCAN: begin
        busy_c = 1'b1;
        if (issue && last_pix) state_nx = DRAIN;
      end
      DRAIN: begin
        busy_c = 1'b1;
        if (adv && upstream_empty) state_nx = FIN;
      end
      FIN: begin
        done_c   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_q <= M_FILL;
      fill_q <= '0;
      x0_q   <= '0;
      x1_q   <= '0;
      y1_q   <= '0;
      x_cnt  <= '0;
      y_cnt  <= '0;
    end else if (state == IDLE && bus.start) begin
      mode_q <= (bus.mode == 2'd3) ? M_FILL : mode_t'(bus.mode);
      fill_q <= bus.fill_color;
      x0_q   <= bus.x0;
      x1_q   <= x1_clamp;
      y1_q   <= y1_clamp;
      x_cnt  <= bus.x0;
      y_cnt  <= bus.y0;
    end else if (issue) begin
      if (x_cnt == x1_q) begin
        x_cnt <= x0_q;
        if (y_cnt != y1_q) y_cnt <= y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pv[i] <= 1'b0;
        px[i] <= '0;
        py[i] <= '0;
      end
    end else if (adv) begin
      pv[0] <= issue;
      px[0] <= x_cnt;
      py[0] <= y_cnt;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        px[i] <= px[i-1];
        py[i] <= py[i-1];
      end
    end
  end

  always_comb begin
    color = fill_q;
    case (mode_q)
      M_MONO:  color = bus.src_q[0] ? fill_q : '0;
      M_COPY:  color = bus.src_q;
      default: color = fill_q;
    endcase
  end

  // The RAM enable is gated with busy so it stays quiet while idle; the pipeline is empty then anyway.
  assign bus.src_rd_en  = busy_c && adv;
  assign bus.src_addr   = (state == SCAN) ?
                          ADDR_W'(32'(y_cnt) * H_RES + 32'(x_cnt)) : '0;
  assign bus.plot       = pv[LAST];
  assign bus.plot_x     = px[LAST];
  assign bus.plot_y     = py[LAST];
  assign bus.plot_color = pv[LAST] ? color : '0;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;

endmodule

// File: doc/rect_blit_engine.md
Name: rect_blit_engine

Overview:
- Parametrised successor to the full-screen background clear scanner.
- Walks an arbitrary rectangle of the framebuffer in raster order and emits one pixel-write request per coordinate to the VGA adapter plot interface.
- Pixel colour comes from one of three modes: solid fill, 1-bit background RAM expanded against a colour, or full-colour source RAM.
- Uses a start/busy/done handshake and ready backpressure, and absorbs source-memory read latency.

Parameters:
- H_RES, 160, horizontal resolution in pixels.
- V_RES, 120, vertical resolution in lines.
- X_W, 8, width of x coordinates.
- Y_W, 7, width of y coordinates.
- COLOR_W, 12, pixel colour width.
- ADDR_W, 15, source memory address width.
- RD_LAT, 1, source memory read latency in cycles; legal range 1..3.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  begin an operation; sampled only in IDLE.
- mode  in  2  0 = fill, 1 = mono expand, 2 = colour copy, 3 = reserved (treated as 0).
- x0, x1  in  X_W  inclusive horizontal bounds.
- y0, y1  in  Y_W  inclusive vertical bounds.
- fill_color  in  COLOR_W  fill or foreground colour.
- src_addr  out  ADDR_W  source read address.
- src_rd_en  out  1  source clock-enable; the memory advances its pipeline only when this is 1.
- src_q  in  COLOR_W  source data; mono mode uses bit 0 only.
- plot  out  1  pixel request valid.
- plot_x  out  X_W  pixel x.
- plot_y  out  Y_W  pixel y.
- plot_color  out  COLOR_W  pixel colour.
- ready  in  1  downstream accepts the pixel this cycle.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: asynchronous on resetn low. State = IDLE; all counters, the pipeline and all outputs go to 0. Reset mid-operation aborts it with no done pulse.
- States:
  - IDLE: waits for start.
  - SCAN: issues coordinates.
  - DRAIN: flushes the pipeline.
  - FIN: pulses done.
- IDLE -> SCAN on start.
  - All inputs (bounds, mode, fill_color) are latched; later changes have no effect.
  - x1 and y1 are clamped to H_RES-1 and V_RES-1.
  - busy = 1 from the next cycle.
- Empty rectangle (x0 > clamped x1, or y0 > clamped y1, or x0 >= H_RES, or y0 >= V_RES): IDLE -> FIN directly; zero plots issued.
- Pipeline advance: adv = !plot || ready. src_rd_en = adv.
- SCAN:
  - Each adv cycle issues the current (x, y) with src_addr = y*H_RES + x, computed at full precision and truncated to ADDR_W.
  - x increments. At the clamped x1, x returns to x0 and y increments.
  - Issuing the last pixel (x1, y1) moves to DRAIN.
- Pipeline: RD_LAT stages of {valid, x, y}, shifting only on adv. The stage output drives plot, plot_x and plot_y. Colour is formed at the output from the latched mode:
  - fill: fill_color.
  - mono: src_q[0] ? fill_color : 0.
  - copy: src_q.
- Output stability: plot_x, plot_y and plot_color must hold stable while plot && !ready.
- DRAIN -> FIN when the pipeline is empty and the last pixel has been accepted (plot && ready).
- FIN: done = 1 for exactly one cycle, busy = 0, then IDLE.
- start is ignored while busy or in FIN.
- Throughput: one pixel per cycle with ready held high. First plot is RD_LAT+1 cycles after the start cycle.
- Pixel count: exactly (x1-x0+1)*(y1-y0+1) plots, in raster order, with no duplicates and no drops under any ready pattern.

Test Plan:
- Fill mode, full screen (0,0)-(159,119), ready = 1 -> 19200 plots in raster order; last plot (159,119); done exactly one cycle after the last plot; busy low afterwards.
- Copy mode, rect (10,5)-(12,6), RD_LAT = 2, source memory holding the value addr -> 6 plots; pixel (12,6) has colour 972; first plot 3 cycles after start.
- Mono mode, fill_color = 12'hF00, src bit0 alternating per address -> colours alternate 12'hF00 / 12'h000, matching a reference model.
- Random ready toggling during a 4x4 copy -> 16 plots; outputs held stable whenever ready = 0; no duplicates.
- x1 = 200, y0 = 3 > y1 = 2 -> zero plots; done pulses; separately, x1 = 200 with valid y clamps to 159.
- resetn low mid-SCAN -> plot, busy and done go low immediately; no done pulse; the next start runs a fresh, correct operation.
